// File: rtl/reservation_entry_alloc_pkg.sv
// rtl/reservation_entry_alloc_pkg.sv - shared sizes and dispatch decode for the reservation station allocator
package reservation_entry_alloc_pkg;

  localparam int RS_ENTRY_N    = 16;
  localparam int RS_INDEX_W    = 4;
  localparam int RS_COUNT_W    = 5;
  localparam int RS_DISP_SLOTS = 2;

  typedef enum logic [1:0] {
    DISP_NONE    = 2'b00,
    DISP_SLOT0   = 2'b01,
    DISP_ILLEGAL = 2'b10,
    DISP_DUAL    = 2'b11
  } disp_kind_e;

  function automatic disp_kind_e decode_disp(input logic [RS_DISP_SLOTS-1:0] req);
    return disp_kind_e'(req);
  endfunction

endpackage

// File: rtl/reservation_free_search16.sv
// rtl/reservation_free_search16.sv - finds the lowest and second-lowest clear bit of a 16-bit valid vector
module reservation_free_search16
  import reservation_entry_alloc_pkg::*;
(
  input  logic [RS_ENTRY_N-1:0] i_valid,
  output logic [RS_INDEX_W-1:0] o_first_idx,
  output logic                  o_first_found,
  output logic [RS_INDEX_W-1:0] o_second_idx,
  output logic                  o_second_found
);

  logic [RS_INDEX_W-1:0] first_idx;
  logic [RS_INDEX_W-1:0] second_idx;
  logic                  first_found;
  logic                  second_found;

  always_comb begin
    first_idx    = '0;
    second_idx   = '0;
    first_found  = 1'b0;
    second_found = 1'b0;
    for (int i = 0; i < RS_ENTRY_N; i++) begin
      if (!i_valid[i]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = RS_INDEX_W'(i);
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = RS_INDEX_W'(i);
        end
      end
    end
  end

  assign o_first_idx    = first_idx;
  assign o_first_found  = first_found;
  assign o_second_idx   = second_idx;
  assign o_second_found = second_found;

endmodule

// File: rtl/reservation_entry_alloc.sv
// rtl/reservation_entry_alloc.sv - 16-entry reservation station slot allocator with valid tracking, free count and dispatch lock
module reservation_entry_alloc
  import reservation_entry_alloc_pkg::*;
#(
  parameter int LOCK_THRESHOLD = 2
)
(
  input  logic                     iCLOCK,
  input  logic                     inRESET,
  input  logic                     iRESET_SYNC,
  input  logic                     iFLUSH,
  input  logic [RS_DISP_SLOTS-1:0] iDISP_VALID,
  output logic                     oDISP_LOCK,
  output logic [RS_INDEX_W-1:0]    oALLOC0_ENTRY,
  output logic [RS_INDEX_W-1:0]    oALLOC1_ENTRY,
  input  logic                     iISSUE_VALID,
  input  logic [RS_INDEX_W-1:0]    iISSUE_ENTRY,
  output logic [RS_ENTRY_N-1:0]    oFREE,
  output logic [RS_COUNT_W-1:0]    oCOUNT,
  output logic                     oERROR
);

  logic [RS_ENTRY_N-1:0] valid_q, valid_d;
  logic [RS_COUNT_W-1:0] count_q, count_d;
  logic                  lock_q, lock_d;
  logic                  err_q, err_d;

  logic [RS_INDEX_W-1:0] idx0, idx1;
  logic                  found0, found1;
  disp_kind_e            disp_kind;
  logic                  accept;
  logic                  grant0, grant1;
  logic                  release_ok;

  reservation_free_search16 u_search (
    .i_valid        (valid_q),
    .o_first_idx    (idx0),
    .o_first_found  (found0),
    .o_second_idx   (idx1),
    .o_second_found (found1)
  );

  always_comb begin
    valid_d    = valid_q;
    count_d    = count_q;
    err_d      = err_q;
    accept     = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    release_ok = 1'b0;
    disp_kind  = decode_disp(iDISP_VALID);

    if (iRESET_SYNC) begin
      valid_d = '0;
      count_d = RS_COUNT_W'(RS_ENTRY_N);
      err_d   = 1'b0;
    end else if (iFLUSH) begin
      valid_d = '0;
      count_d = RS_COUNT_W'(RS_ENTRY_N);
    end else begin
      if (disp_kind != DISP_NONE) begin
        if (lock_q || disp_kind == DISP_ILLEGAL) begin
          err_d = 1'b1;
        end else begin
          accept = 1'b1;
          grant0 = found0;
          grant1 = (disp_kind == DISP_DUAL) && found1;
          // Only reachable with a threshold below the slot count.
          if (!found0 || (disp_kind == DISP_DUAL && !found1)) begin
            err_d = 1'b1;
          end
        end
      end

      if (iISSUE_VALID) begin
        if (valid_q[iISSUE_ENTRY]) begin
          release_ok = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      // Grants come from the pre-edge free vector, so they never alias the released entry.
      if (release_ok) valid_d[iISSUE_ENTRY] = 1'b0;
      if (grant0)     valid_d[idx0] = 1'b1;
      if (grant1)     valid_d[idx1] = 1'b1;

      count_d = count_q + RS_COUNT_W'(release_ok) - RS_COUNT_W'(grant0) - RS_COUNT_W'(grant1);
    end

    lock_d = (count_d < RS_COUNT_W'(LOCK_THRESHOLD));
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      valid_q <= '0;
      count_q <= RS_COUNT_W'(RS_ENTRY_N);
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign oFREE         = ~valid_q;
  assign oCOUNT        = count_q;
  assign oDISP_LOCK    = lock_q;
  assign oERROR        = err_q;
  assign oALLOC0_ENTRY = idx0;
  assign oALLOC1_ENTRY = idx1;

  a_count_matches_free: assert property (@(posedge iCLOCK) disable iff (!inRESET)
    count_q == RS_COUNT_W'($countones(~valid_q)));

  a_slot0_has_entry: assert property (@(posedge iCLOCK) disable iff (!inRESET)
    accept |-> found0);

  a_dual_has_entries: assert property (@(posedge iCLOCK) disable iff (!inRESET)
    (accept && disp_kind == DISP_DUAL && LOCK_THRESHOLD >= RS_DISP_SLOTS) |-> found1);

endmodule
